wb_daq_channel_scheduler: RTL and testbench
===========================================

# wb_daq_channel_scheduler

Wishbone master-side scheduler that drains the four DAQ channel sample FIFOs into memory. Each channel's base address, length and mode come from the DAQ slave register block. A 4-way round-robin arbiter picks one requesting channel at a time and issues single 32-bit Wishbone writes to `base + 4*index`. Per-channel progress and status are reported back to the register block's status inputs.

## Interface
- `dw`, 32, data/address width.
- `wb_clk` in 1: clock.
- `wb_rst_n` in 1: reset, synchronous, active-low.
- `daq_control_reg` in dw: bit0 = global enable.
- `chan_address_i` in 4*dw: channel n base address at `[n*dw +: dw]`; bits[1:0] ignored.
- `chan_control_i` in 4*dw, per channel:
  - bit0 = enable
  - bit1 = wrap mode
  - bit4 = interrupt enable
  - [31:16] = length in words
  - all other bits ignored
- `fifo_empty_i` in 4: per-channel FIFO empty.
- `fifo_dat_i` in 4*dw: first-word-fall-through FIFO heads.
- `fifo_rd_o` out 4: one-cycle pop strobe.
- `wbm_adr_o` out dw, `wbm_dat_o` out dw, `wbm_sel_o` out 4, `wbm_we_o` out 1, `wbm_cyc_o` out 1, `wbm_stb_o` out 1, `wbm_cti_o` out 3, `wbm_bte_o` out 2: Wishbone master outputs.
- `wbm_ack_i` in 1, `wbm_err_i` in 1, `wbm_rty_i` in 1: Wishbone master responses.
- `chan_status_o` out 4*dw, per channel:
  - [15:0] = index
  - bit16 = done
  - bit17 = wrapped
  - bit18 = error
  - bit19 = granted
  - other bits 0
- `interrupt` out 1: level, OR over channels of (done|error) & int-enable.
- `busy_o` out 1: high whenever state is WRITE.

## Operation
- **Channel request:**
  - req[n] = global enable & ctrl[n].bit0 & ~fifo_empty[n] & ~done[n] & ~error[n] & length[n]≠0.
- **FSM states: IDLE, WRITE.**
- **IDLE:**
  - If any req, the arbiter grants the first requesting channel searching from last_grant+1 (mod 4).
  - last_grant resets to 3, so channel 0 has first priority.
  - The grant is registered and the FSM moves to WRITE.
- **WRITE:**
  - Drives cyc=stb=we=1, sel=4'hF, cti=3'b000, bte=2'b00.
  - adr = base + {index, 2'b00}; dat = fifo_dat of the granted channel.
  - All are held stable until a response arrives.
- **ack:**
  - fifo_rd_o[grant] = 1 for that cycle only.
  - Index advances and FSM returns to IDLE.
  - If index == length-1: wrap mode sets index=0 and wrapped=1 (sticky); otherwise done=1 and index holds.
- **err:**
  - No pop; error[grant]=1 (sticky); return to IDLE.
- **rty:**
  - No pop, no state change to the channel; return to IDLE and re-arbitrate.
- **Priority:** ack > err > rty if more than one is asserted in the same cycle.
- **Channel enable low** (ctrl bit0 = 0): index, done, wrapped and error all clear to 0 on the next edge.
  - If that channel is mid-WRITE, the bus cycle still completes and the pop still occurs on ack.
  - The clear wins over the index increment.
- **Global enable low:** no new grants; an in-flight WRITE completes normally.
- **Length changed mid-run:** compare is against the live value. If index ≥ new length-1 at ack, the same terminal rule applies.

## Timing
- **Reset values:** all Wishbone outputs 0, fifo_rd_o=0, interrupt=0, busy_o=0, chan_status_o=0. Index/done/wrapped/error clear; state IDLE.
- **Reset asserted mid-WRITE:** cyc/stb drop at the next edge with no pop.
- **Grant latency:** 1 cycle. A request seen in IDLE cycle t gives stb high in cycle t+1.
- **Throughput:** ack in cycle t+1 returns to IDLE at t+2. This gives at most 1 word per 2 cycles, with zero-wait slaves.
- **Wishbone outputs:** registered.
- **fifo_rd_o:** combinational = onehot(grant) & {4{WRITE & ack}}.
- **Status and interrupt:** registered, update 1 cycle after the causing event.
- **Index increment:** 16-bit. Length 16'hFFFF is valid; length 0 means the channel is never requested.

## Structure
- Shared include header `wb_daq_include.vh` holds:
  - control bit positions (ENABLE=0, WRAP=1, INTEN=4, LEN=31:16)
  - status bit positions (DONE=16, WRAP=17, ERR=18, GRANT=19)
  - FSM state encodings
- Sub-module `daq_rr_arbiter`:
  - combinational 4-way round robin
  - inputs: req[3:0], last[1:0]
  - outputs: gnt_onehot[3:0], gnt_idx[1:0], any
- The top level holds the FSM, per-channel counters and status.

## Test plan
- **Single channel:** ch0 base 0x1000, length 3, FIFO holds A,B,C, zero-wait ack.
  - Writes to 0x1000/0x1004/0x1008 with A,B,C; 3 pops.
  - ch0 done=1, index=2; interrupt high if INTEN=1.
- **Round robin:** all 4 channels enabled with data.
  - Grant order 0,1,2,3,0,…; each channel's addresses advance by 4.
- **Wrap:** ch2 length 2, wrap=1, 5 words.
  - Addresses base, +4, base, +4, base; wrapped=1, done=0.
- **err/rty:**
  - err on ch1's first write: no pop, error=1, ch1 skipped thereafter.
  - rty on ch3: same address retried after re-arbitration; 1 pop total.
- **Disable mid-WRITE:** deassert ch0 enable during 3 wait states.
  - The bus cycle completes with 1 pop; ch0 status then reads 0.
- **Reset mid-WRITE:** wb_rst_n=0 during stb.
  - All outputs 0 next edge; no pop; ch0 grant first after release.

Source files
------------

// File: rtl/wb_daq_channel_scheduler_pkg.sv
// Shared field positions, FSM encoding and helpers for the DAQ channel scheduler.
package wb_daq_channel_scheduler_pkg;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_WRAP    = 1;
  localparam int CTRL_INTEN   = 4;
  localparam int CTRL_LEN_LSB = 16;
  localparam int CTRL_LEN_W   = 16;

  localparam int STAT_DONE  = 16;
  localparam int STAT_WRAP  = 17;
  localparam int STAT_ERR   = 18;
  localparam int STAT_GRANT = 19;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/wb_daq_channel_scheduler_arbiter.sv
// Combinational 4-way round-robin arbiter: searches from last+1 upward, wrapping.
module daq_rr_arbiter
  import wb_daq_channel_scheduler_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_onehot_o,
  output logic [1:0] gnt_idx_o,
  output logic       any_o
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt_idx_o = 2'd0;
    found     = 1'b0;
    cand      = 2'd0;
    // i == 4 lands back on last itself, so it only wins when nobody else asks
    for (int i = 1; i <= 4; i++) begin
      cand = last_i + i[1:0];
      if (!found && req_i[cand]) begin
        gnt_idx_o = cand;
        found     = 1'b1;
      end
    end
    any_o        = found;
    gnt_onehot_o = found ? onehot4(gnt_idx_o) : 4'b0000;
  end

endmodule

// File: rtl/wb_daq_channel_scheduler.sv
// Drains four DAQ sample FIFOs into memory with single Wishbone writes,
// one round-robin-selected channel at a time, and reports per-channel progress.
module wb_daq_channel_scheduler
  import wb_daq_channel_scheduler_pkg::*;
#(
  parameter int dw = 32
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [dw-1:0]   daq_control_reg,
  input  logic [4*dw-1:0] chan_address_i,
  input  logic [4*dw-1:0] chan_control_i,
  input  logic [3:0]      fifo_empty_i,
  input  logic [4*dw-1:0] fifo_dat_i,
  output logic [3:0]      fifo_rd_o,
  output logic [dw-1:0]   wbm_adr_o,
  output logic [dw-1:0]   wbm_dat_o,
  output logic [3:0]      wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i,
  output logic [4*dw-1:0] chan_status_o,
  output logic            interrupt,
  output logic            busy_o
);

  state_e          state_q;
  logic [1:0]      grant_q, last_q;
  logic [3:0]      grant_oh_q;
  logic [dw-1:0]   adr_q, dat_q;
  logic [3:0]      sel_q;
  logic            cyc_q, stb_q, we_q, irq_q;

  logic [3:0]      req, irq_next, arb_oh;
  logic [1:0]      arb_idx;
  logic            arb_any, ack_fire, err_fire, busy;
  logic [3:0][15:0] idx_all;
  logic [dw-1:0]   base_arr [4];
  logic [dw-1:0]   head_arr [4];
  logic            unused_glob;

  assign busy     = (state_q == ST_WRITE);
  assign ack_fire = busy & wbm_ack_i;
  assign err_fire = busy & ~wbm_ack_i & wbm_err_i;
  assign unused_glob = ^daq_control_reg[dw-1:1];

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    logic [dw-1:0] ctrl, status;
    logic [15:0]   len, index_q, index_d;
    logic          en, mine, unused_bits;
    logic          done_q, done_d, wrapped_q, wrapped_d, error_q, error_d;

    assign ctrl = chan_control_i[gi*dw +: dw];
    assign len  = ctrl[CTRL_LEN_LSB +: CTRL_LEN_W];
    assign en   = ctrl[CTRL_ENABLE];
    assign mine = (grant_q == 2'(gi));
    assign base_arr[gi] = chan_address_i[gi*dw +: dw];
    assign head_arr[gi] = fifo_dat_i[gi*dw +: dw];
    assign unused_bits  = ^{ctrl[3:2], ctrl[15:5], chan_address_i[gi*dw +: 2]};

    // Terminal test uses the live length, so a shrunk length still ends the run.
    always_comb begin
      index_d   = index_q;
      done_d    = done_q;
      wrapped_d = wrapped_q;
      error_d   = error_q;
      if (!en) begin
        index_d   = 16'd0;
        done_d    = 1'b0;
        wrapped_d = 1'b0;
        error_d   = 1'b0;
      end else if (ack_fire && mine) begin
        if ({1'b0, index_q} + 17'd1 >= {1'b0, len}) begin
          if (ctrl[CTRL_WRAP]) begin
            index_d   = 16'd0;
            wrapped_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          index_d = index_q + 16'd1;
        end
      end else if (err_fire && mine) begin
        error_d = 1'b1;
      end
    end

    always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
        index_q   <= 16'd0;
        done_q    <= 1'b0;
        wrapped_q <= 1'b0;
        error_q   <= 1'b0;
      end else begin
        index_q   <= index_d;
        done_q    <= done_d;
        wrapped_q <= wrapped_d;
        error_q   <= error_d;
      end
    end

    always_comb begin
      status             = '0;
      status[15:0]       = index_q;
      status[STAT_DONE]  = done_q;
      status[STAT_WRAP]  = wrapped_q;
      status[STAT_ERR]   = error_q;
      status[STAT_GRANT] = busy & mine;
    end

    assign req[gi] = daq_control_reg[0] & en & ~fifo_empty_i[gi] & ~done_q & ~error_q
                     & (len != 16'd0);
    assign irq_next[gi] = (done_d | error_d) & ctrl[CTRL_INTEN];
    assign idx_all[gi]  = index_q;
    assign chan_status_o[gi*dw +: dw] = status;
  end

  daq_rr_arbiter u_arb (
    .req_i        (req),
    .last_i       (last_q),
    .gnt_onehot_o (arb_oh),
    .gnt_idx_o    (arb_idx),
    .any_o        (arb_any)
  );

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'd0;
      grant_oh_q <= 4'd0;
      last_q     <= 2'd3;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= 4'h0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_q <= |irq_next;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q    <= ST_WRITE;
            grant_q    <= arb_idx;
            grant_oh_q <= arb_oh;
            last_q     <= arb_idx;
            adr_q      <= {base_arr[arb_idx][dw-1:2], 2'b00}
                          + {{(dw-18){1'b0}}, idx_all[arb_idx], 2'b00};
            dat_q      <= head_arr[arb_idx];
            sel_q      <= 4'hF;
            cyc_q      <= 1'b1;
            stb_q      <= 1'b1;
            we_q       <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wbm_ack_i || wbm_err_i || wbm_rty_i) begin
            state_q <= ST_IDLE;
            sel_q   <= 4'h0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pop is gated by reset so an ack racing a reset never consumes a sample.
  assign fifo_rd_o = grant_oh_q & {4{ack_fire & wb_rst_n}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign interrupt = irq_q;
  assign busy_o    = busy;

endmodule

// File: tb/tb_wb_daq_channel_scheduler.sv
// Self-checking bench: transaction-level reference model of the channel scheduler.
module tb_wb_daq_channel_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  gctl;
  logic [31:0]  base [4];
  logic [31:0]  ctrl [4];
  logic [127:0] chan_address, chan_control, fifo_dat, chan_status;
  logic [3:0]   fifo_empty, fifo_rd, wb_sel;
  logic [31:0]  wb_adr, wb_dat;
  logic         wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty, irq, busy;
  logic [2:0]   wb_cti;
  logic [1:0]   wb_bte;

  assign chan_address = {base[3], base[2], base[1], base[0]};
  assign chan_control = {ctrl[3], ctrl[2], ctrl[1], ctrl[0]};

  wb_daq_channel_scheduler #(.dw(32)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .daq_control_reg(gctl),
    .chan_address_i(chan_address), .chan_control_i(chan_control),
    .fifo_empty_i(fifo_empty), .fifo_dat_i(fifo_dat), .fifo_rd_o(fifo_rd),
    .wbm_adr_o(wb_adr), .wbm_dat_o(wb_dat), .wbm_sel_o(wb_sel), .wbm_we_o(wb_we),
    .wbm_cyc_o(wb_cyc), .wbm_stb_o(wb_stb), .wbm_cti_o(wb_cti), .wbm_bte_o(wb_bte),
    .wbm_ack_i(wb_ack), .wbm_err_i(wb_err), .wbm_rty_i(wb_rty),
    .chan_status_o(chan_status), .interrupt(irq), .busy_o(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] fq [4][$];
  int tests = 0;
  int fails = 0;

  int          m_idx [4];
  bit          m_done [4], m_wrap [4], m_err [4];
  bit          m_write, m_irq;
  int          m_grant, m_last;
  logic [31:0] m_adr, m_dat;

  bit          prev_stb;
  int          grant_log [$];
  logic [31:0] adr_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int n = 0; n < 4; n++) begin
      fifo_empty[n] = (fq[n].size() == 0);
      fifo_dat[n*32 +: 32] = (fq[n].size() != 0) ? fq[n][0] : (32'hDEAD_0000 + 32'(n));
    end
  endtask

  // Advance the reference model across one clock edge using the pre-edge view.
  task automatic model_edge(input bit a, input bit e, input bit r);
    bit found;
    int c;
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        m_idx[n] = 0; m_done[n] = 0; m_wrap[n] = 0; m_err[n] = 0;
      end
      m_write = 0; m_last = 3; m_grant = 0; m_irq = 0;
      return;
    end
    if (m_write) begin
      c = m_grant;
      if (a) begin
        if (m_idx[c] + 1 >= int'(ctrl[c][31:16])) begin
          if (ctrl[c][1]) begin m_idx[c] = 0; m_wrap[c] = 1; end
          else m_done[c] = 1;
        end else m_idx[c] = m_idx[c] + 1;
      end else if (e) m_err[c] = 1;
      if (a || e || r) m_write = 0;
    end else begin
      found = 0;
      for (int i = 1; i <= 4; i++) begin
        c = (m_last + i) % 4;
        if (!found && gctl[0] && ctrl[c][0] && fq[c].size() > 0 && !m_done[c] && !m_err[c]
            && ctrl[c][31:16] != 16'd0) begin
          found = 1; m_write = 1; m_grant = c; m_last = c;
          m_adr = (base[c] & 32'hFFFF_FFFC) + 32'(m_idx[c] * 4);
          m_dat = fq[c][0];
        end
      end
    end
    m_irq = 0;
    for (int n = 0; n < 4; n++) begin
      if (!ctrl[n][0]) begin
        m_idx[n] = 0; m_done[n] = 0; m_wrap[n] = 0; m_err[n] = 0;
      end
      if ((m_done[n] || m_err[n]) && ctrl[n][4]) m_irq = 1;
    end
  endtask

  // resp: 0 none, 1 ack, 2 err, 3 rty, 4 random, 5 ack+err+rty together
  task automatic step(input int resp);
    int r, v, g;
    bit a, e, rt;
    logic [3:0] rd_exp, rd_s;
    drive_fifo();
    check("cyc", wb_cyc, m_write);
    check("stb", wb_stb, m_write);
    check("we", wb_we, m_write);
    check("sel", wb_sel, m_write ? 4'hF : 4'h0);
    check("busy", busy, m_write);
    check("cti_bte", {wb_cti, wb_bte}, 5'd0);
    if (m_write) begin
      check("adr", wb_adr, m_adr);
      check("dat", wb_dat, m_dat);
    end
    for (int n = 0; n < 4; n++)
      check($sformatf("status%0d", n), chan_status[n*32 +: 32],
            {12'd0, m_write && m_grant == n, m_err[n], m_wrap[n], m_done[n], 16'(m_idx[n])});
    check("irq", irq, m_irq);
    if (wb_stb && !prev_stb) begin
      g = -1;
      for (int n = 0; n < 4; n++) if (chan_status[n*32 + 19]) g = n;
      grant_log.push_back(g);
      adr_log.push_back(wb_adr);
    end
    prev_stb = wb_stb;
    r = resp;
    if (r == 4) begin
      v = $urandom_range(0, 99);
      r = (v < 55) ? 1 : (v < 78) ? 0 : (v < 92) ? 3 : 2;
    end
    a  = m_write && (r == 1 || r == 5);
    e  = m_write && (r == 2 || r == 5);
    rt = m_write && (r == 3 || r == 5);
    wb_ack = a; wb_err = e; wb_rty = rt;
    #1;
    rd_exp = (a && rst_n) ? 4'(1 << m_grant) : 4'b0000;
    check("fifo_rd", fifo_rd, rd_exp);
    rd_s = fifo_rd;
    $display("[TB] t=%0t resp=%0d stb=%0b adr=%h dat=%h rd=%b", $time, r, wb_stb, wb_adr, wb_dat, rd_s);
    model_edge(a, e, rt);
    @(posedge clk); #1;
    wb_ack = 0; wb_err = 0; wb_rty = 0;
    for (int n = 0; n < 4; n++)
      if (rd_s[n] && fq[n].size() > 0) void'(fq[n].pop_front());
  endtask

  task automatic run_until_write(input int maxc, input string tag);
    int k = 0;
    while (!m_write && k < maxc) begin step(0); k++; end
    check(tag, m_write, 1);
  endtask

  task automatic quiesce();
    int k = 0;
    for (int n = 0; n < 4; n++) ctrl[n] = 32'd0;
    while (m_write && k < 50) begin step(1); k++; end
    check("quiesce", m_write, 0);
    for (int n = 0; n < 4; n++) fq[n].delete();
    step(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] adr_a;
    int n;
    rst_n = 0; gctl = 0; wb_ack = 0; wb_err = 0; wb_rty = 0;
    fifo_empty = 4'hF; fifo_dat = '0; prev_stb = 0;
    for (int i = 0; i < 4; i++) begin base[i] = 0; ctrl[i] = 0; end
    model_edge(0, 0, 0);
    @(posedge clk); #1;
    step(0); step(0);
    rst_n = 1;
    step(0);

    // single channel, three words
    base[0] = 32'h1000; ctrl[0] = 32'h0003_0011; gctl = 1;
    fq[0].push_back(32'hAAAA_0001); fq[0].push_back(32'hBBBB_0002); fq[0].push_back(32'hCCCC_0003);
    adr_log.delete(); grant_log.delete();
    repeat (10) step(1);
    check("t1_status", chan_status[31:0], 32'h0001_0002);
    check("t1_irq", irq, 1);
    check("t1_fifo", fq[0].size(), 0);
    check("t1_nwr", adr_log.size(), 3);
    for (int k = 0; k < 3; k++)
      check("t1_adr", (k < adr_log.size()) ? adr_log[k] : 32'hX, 32'h1000 + 32'(4 * k));

    // round robin across all four channels
    for (int i = 0; i < 4; i++) ctrl[i] = 0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      base[i] = $urandom();
      ctrl[i] = 32'h0006_0001;
      repeat (4) fq[i].push_back($urandom());
    end
    adr_log.delete(); grant_log.delete();
    repeat (40) step(1);
    check("t2_nwr", grant_log.size(), 16);
    for (int k = 0; k < 8; k++)
      check("t2_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hX, 32'((k + 1) % 4));

    // randomized traffic with random bus responses and control churn
    for (int cyc = 0; cyc < 300; cyc++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, 3);
        if (fq[n].size() < 8) fq[n].push_back($urandom());
      end
      if ($urandom_range(0, 40) == 0) begin
        n = $urandom_range(0, 3);
        ctrl[n] = ($urandom_range(1, 6) << 16) | ($urandom_range(0, 1) << 4)
                | ($urandom_range(0, 1) << 1) | 32'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 60) == 0) gctl[0] = ~gctl[0];
      step(4);
    end
    gctl = 1;
    quiesce();

    // wrap mode on channel 2
    base[2] = 32'h2000; ctrl[2] = 32'h0002_0003;
    repeat (5) fq[2].push_back($urandom());
    adr_log.delete();
    repeat (14) step(1);
    check("t4_nwr", adr_log.size(), 5);
    for (int k = 0; k < 5; k++)
      check("t4_adr", (k < adr_log.size()) ? adr_log[k] : 32'hX, 32'h2000 + 32'(4 * (k % 2)));
    check("t4_status", chan_status[64 +: 32], 32'h0002_0001);
    quiesce();

    // error on ch1, retry and simultaneous responses on ch3
    base[1] = 32'h3000; ctrl[1] = 32'h0004_0001;
    fq[1].push_back(32'h1111_0000); fq[1].push_back(32'h1111_0001);
    run_until_write(8, "t5_w1");
    check("t5_g1", chan_status[32 + 19], 1);
    step(2);
    check("t5_err", chan_status[32 + 18], 1);
    check("t5_nopop1", fq[1].size(), 2);
    repeat (4) step(1);
    base[3] = 32'h4000; ctrl[3] = 32'h0004_0001;
    fq[3].push_back(32'h3333_0000); fq[3].push_back(32'h3333_0001);
    run_until_write(8, "t5_w3");
    adr_a = wb_adr;
    check("t5_adr3", adr_a, 32'h4000);
    step(3);
    run_until_write(8, "t5_w3b");
    check("t5_retry_adr", wb_adr, 32'h4000);
    check("t5_nopop3", fq[3].size(), 2);
    step(5);
    check("t5_pop3", fq[3].size(), 1);
    check("t5_status3", chan_status[96 +: 32], 32'h0000_0001);
    quiesce();

    // channel disabled during wait states
    base[0] = 32'h5000; ctrl[0] = 32'h0004_0001;
    fq[0].push_back(32'h5555_0000); fq[0].push_back(32'h5555_0001);
    run_until_write(8, "t6_w");
    step(0);
    ctrl[0] = 0;
    step(0); step(0); step(1);
    check("t6_pop", fq[0].size(), 1);
    check("t6_status", chan_status[31:0], 32'h0);
    check("t6_cyc", wb_cyc, 0);
    quiesce();

    // reset in the middle of a write
    ctrl[0] = 32'h0004_0001; ctrl[1] = 32'h0004_0001;
    fq[0].push_back(32'h7777_0000); fq[1].push_back(32'h7777_0001);
    run_until_write(8, "t7_w");
    rst_n = 0;
    step(1);
    check("t7_stb", wb_stb, 0);
    check("t7_cyc", wb_cyc, 0);
    check("t7_nopop0", fq[0].size(), 1);
    check("t7_nopop1", fq[1].size(), 1);
    step(0);
    rst_n = 1;
    run_until_write(8, "t7_w2");
    check("t7_first_ch0", chan_status[19], 1);
    step(1); step(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
